obi_rr_arbiter: RTL and testbench
=================================

OBI_RR_ARBITER -- requirements
Module: obi_rr_arbiter

Interface
REQ-001 Parameter OBI_AW, default 32, address width in bits.
REQ-002 Parameter OBI_DW, default 32, data width in bits.
REQ-003 Parameter TIMEOUT, default 255, range 0..65535; response-timeout limit in cycles; 0 disables the timeout.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Ports m0_req/m1_req  input  1 each  manager request.
REQ-007 Ports m0_addr/m1_addr  input  OBI_AW each  address.
REQ-008 Ports m0_we/m1_we  input  1 each  write enable.
REQ-009 Ports m0_be/m1_be  input  OBI_DW/8 each  byte enables.
REQ-010 Ports m0_wdata/m1_wdata  input  OBI_DW each  write data.
REQ-011 Ports m0_rready/m1_rready  input  1 each  response ready.
REQ-012 Ports m0_gnt/m1_gnt, m0_rvalid/m1_rvalid, m0_err/m1_err  output  1 each; m0_rdata/m1_rdata  output  OBI_DW each.
REQ-013 Ports s_req, s_we, s_rready  output  1; s_addr  output  OBI_AW; s_be  output  OBI_DW/8; s_wdata  output  OBI_DW.
REQ-014 Ports s_gnt, s_rvalid, s_err  input  1; s_rdata  input  OBI_DW.
REQ-015 Port timeout_o  output  1  one-cycle pulse on response timeout.
REQ-016 Port busy_o  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, RSP, ERR_RSP and DRAIN; it leaves reset in IDLE.
REQ-018 IDLE arbitration SHALL be round-robin: with a single requester, that requester wins; with both requesting, the manager not pointed to by the 1-bit last-winner register (reset 1) wins, so m0 wins first.
REQ-019 In IDLE, s_req SHALL be the winner's req, and s_addr/s_we/s_be/s_wdata SHALL be combinationally muxed from the winner.
REQ-020 The winner's gnt SHALL equal s_gnt; the loser's gnt SHALL be 0.
REQ-021 Lock: if s_req=1 and s_gnt=0, the winner SHALL be registered and held until a grant occurs; a newly arriving higher-priority request SHALL NOT change the selection while the request is pending.
REQ-022 On an address handshake (s_req & s_gnt), the block SHALL record the owner, update last-winner to the owner, clear the timeout counter and enter RSP.
REQ-023 Only one transaction SHALL be outstanding: in RSP, ERR_RSP and DRAIN, s_req=0 and both gnt=0.
REQ-024 In RSP, the owner's rvalid/rdata/err SHALL be driven from s_rvalid/s_rdata/s_err; s_rready SHALL be the owner's rready.
REQ-025 The non-owner's rvalid and err SHALL be 0 and its rdata SHALL be 0.
REQ-026 In RSP, s_rvalid & owner rready SHALL return the FSM to IDLE; a new request SHALL be arbitrated in the following cycle (no same-cycle re-grant).
REQ-027 In RSP, the 16-bit timeout counter SHALL increment each cycle s_rvalid=0 and saturate at 16'hFFFF.
REQ-028 With TIMEOUT≠0 and the counter equal to TIMEOUT-1 while s_rvalid=0, the block SHALL pulse timeout_o for one cycle and enter ERR_RSP.
REQ-029 In ERR_RSP, owner rvalid=1, err=1 and rdata=32'hDEAD_BEEF (zero-extended or truncated to OBI_DW); s_rready=1 and late subordinate responses are accepted and discarded.
REQ-030 Leaving ERR_RSP on owner rready: if a late subordinate response has already been seen, go to IDLE; otherwise go to DRAIN.
REQ-031 In DRAIN, s_rready=1, no manager rvalid is asserted, and the FSM SHALL go to IDLE on s_rvalid.
REQ-032 A simultaneous s_rvalid and timeout in the same cycle SHALL be treated as a normal response; no timeout is raised.
REQ-033 With TIMEOUT=0, the FSM SHALL never enter ERR_RSP or DRAIN.

Reset
REQ-034 Asserting reset_n=0 SHALL immediately force: state IDLE, last-winner=1, lock cleared, timeout counter 0, timeout_o=0, busy_o=0, both gnt/rvalid/err=0, s_req=0 and s_rready=0, including mid-transaction. Any outstanding transaction is abandoned with no response.
REQ-035 Reset deassertion SHALL take effect synchronously to the clk edge.

Verification
REQ-036 Both managers request continuously with s_gnt=1 and a response 1 cycle later -> grants alternate m0, m1, m0, m1; each rdata is routed only to its own manager.
REQ-037 m0 requests with s_gnt=0 for 3 cycles while m1 asserts req in cycle 2 -> s_addr stays m0_addr throughout; m0_gnt is asserted in cycle 4; m1 is served next.
REQ-038 TIMEOUT=4 with no s_rvalid after the grant -> timeout_o pulses in cycle 4 after the grant; the owner receives err=1 and rdata=32'hDEAD_BEEF; a late s_rvalid 3 cycles later is drained; the block returns to IDLE.
REQ-039 Owner rready=0 for 5 cycles while s_rvalid=1 -> s_rready=0, rvalid is held with stable rdata, and the FSM stays in RSP until rready.
REQ-040 reset_n is pulsed low during RSP -> all outputs are 0 immediately; after release, m0 wins a simultaneous request.
REQ-041 s_rvalid arrives in the same cycle the counter reaches TIMEOUT-1 -> a normal response is delivered; timeout_o stays 0.

Source files
------------

// File: rtl/obi_rr_arbiter_if.sv
// Bus bundle for the two-manager OBI round-robin arbiter: both manager ports
// and the single subordinate port. The slave modport is the arbiter's view.
interface obi_rr_arbiter_if #(
  parameter int OBI_AW = 32,
  parameter int OBI_DW = 32
) ();
  logic                m0_req,    m1_req;
  logic [OBI_AW-1:0]   m0_addr,   m1_addr;
  logic                m0_we,     m1_we;
  logic [OBI_DW/8-1:0] m0_be,     m1_be;
  logic [OBI_DW-1:0]   m0_wdata,  m1_wdata;
  logic                m0_rready, m1_rready;
  logic                m0_gnt,    m1_gnt;
  logic                m0_rvalid, m1_rvalid;
  logic                m0_err,    m1_err;
  logic [OBI_DW-1:0]   m0_rdata,  m1_rdata;

  logic                s_req, s_we, s_rready;
  logic [OBI_AW-1:0]   s_addr;
  logic [OBI_DW/8-1:0] s_be;
  logic [OBI_DW-1:0]   s_wdata;
  logic                s_gnt, s_rvalid, s_err;
  logic [OBI_DW-1:0]   s_rdata;

  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_be, m1_be,
           m0_wdata, m1_wdata, m0_rready, m1_rready,
           s_gnt, s_rvalid, s_err, s_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err,
           m0_rdata, m1_rdata,
           s_req, s_we, s_rready, s_addr, s_be, s_wdata
  );

  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_be, m1_be,
           m0_wdata, m1_wdata, m0_rready, m1_rready,
           s_gnt, s_rvalid, s_err, s_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err,
           m0_rdata, m1_rdata,
           s_req, s_we, s_rready, s_addr, s_be, s_wdata
  );
endinterface

// File: rtl/obi_rr_arbiter.sv
// Two-manager OBI arbiter: round-robin address phase, one outstanding
// transaction, response routing to the owner and an optional response timeout.
module obi_rr_arbiter #(
  parameter int OBI_AW  = 32,
  parameter int OBI_DW  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  obi_rr_arbiter_if.slave   bus,
  output logic              timeout_o,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, RSP, ERR_RSP, DRAIN} state_e;

  localparam logic [OBI_DW-1:0] ERR_DATA = OBI_DW'(32'hDEAD_BEEF);
  localparam logic [15:0]       TO_LAST  = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        lock_q, lock_d;
  logic        lock_sel_q, lock_sel_d;
  logic        owner_q, owner_d;
  logic        late_q, late_d;
  logic [15:0] cnt_q, cnt_d;

  logic [1:0]                     req, we, rready;
  logic [1:0][OBI_AW-1:0]         addr;
  logic [1:0][OBI_DW/8-1:0]       be;
  logic [1:0][OBI_DW-1:0]         wdata;
  logic [1:0]                     gnt, rvalid, err;
  logic [1:0][OBI_DW-1:0]         rdata;
  logic                           win, tmo_hit, tmo;

  assign req    = {bus.m1_req,    bus.m0_req};
  assign we     = {bus.m1_we,     bus.m0_we};
  assign rready = {bus.m1_rready, bus.m0_rready};
  assign addr   = {bus.m1_addr,   bus.m0_addr};
  assign be     = {bus.m1_be,     bus.m0_be};
  assign wdata  = {bus.m1_wdata,  bus.m0_wdata};

  // A stalled request keeps its winner so a late arrival cannot steal the slot.
  always_comb begin
    if (lock_q)          win = lock_sel_q;
    else if (&req)       win = ~last_q;
    else                 win = req[1] & ~req[0];
  end

  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST) && !bus.s_rvalid;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    lock_d       = lock_q;
    lock_sel_d   = lock_sel_q;
    owner_d      = owner_q;
    late_d       = late_q;
    cnt_d        = cnt_q;
    bus.s_req    = 1'b0;
    bus.s_we     = 1'b0;
    bus.s_addr   = '0;
    bus.s_be     = '0;
    bus.s_wdata  = '0;
    bus.s_rready = 1'b0;
    gnt          = '0;
    rvalid       = '0;
    err          = '0;
    rdata        = '0;
    tmo          = 1'b0;
    // Outputs are forced quiet combinationally while reset is held.
    if (reset_n) begin
      unique case (state_q)
        IDLE: begin
          bus.s_req   = req[win];
          bus.s_we    = we[win];
          bus.s_addr  = addr[win];
          bus.s_be    = be[win];
          bus.s_wdata = wdata[win];
          gnt[win]    = bus.s_gnt;
          if (req[win] && bus.s_gnt) begin
            owner_d = win;
            last_d  = win;
            cnt_d   = '0;
            lock_d  = 1'b0;
            late_d  = 1'b0;
            state_d = RSP;
          end else if (req[win]) begin
            lock_d     = 1'b1;
            lock_sel_d = win;
          end else begin
            lock_d = 1'b0;
          end
        end
        RSP: begin
          bus.s_rready   = rready[owner_q];
          rvalid[owner_q] = bus.s_rvalid;
          err[owner_q]    = bus.s_err;
          rdata[owner_q]  = bus.s_rdata;
          if (bus.s_rvalid && rready[owner_q]) begin
            state_d = IDLE;
          end else if (tmo_hit) begin
            tmo     = 1'b1;
            late_d  = 1'b0;
            state_d = ERR_RSP;
          end
          if (!bus.s_rvalid && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
        ERR_RSP: begin
          bus.s_rready    = 1'b1;
          rvalid[owner_q] = 1'b1;
          err[owner_q]    = 1'b1;
          rdata[owner_q]  = ERR_DATA;
          if (bus.s_rvalid) late_d = 1'b1;
          // A late response in this very cycle counts as already seen.
          if (rready[owner_q]) state_d = (late_q || bus.s_rvalid) ? IDLE : DRAIN;
        end
        DRAIN: begin
          bus.s_rready = 1'b1;
          if (bus.s_rvalid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      owner_q    <= 1'b0;
      late_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      owner_q    <= owner_d;
      late_q     <= late_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_rvalid = rvalid[0];
  assign bus.m1_rvalid = rvalid[1];
  assign bus.m0_err    = err[0];
  assign bus.m1_err    = err[1];
  assign bus.m0_rdata  = rdata[0];
  assign bus.m1_rdata  = rdata[1];
  assign timeout_o     = tmo;
  assign busy_o        = reset_n && (state_q != IDLE);
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Bench for obi_rr_arbiter: directed scenarios followed by random traffic, all
// cycles compared against a transaction-level reference model.
module tb_obi_rr_arbiter;
  localparam int AW = 32, DW = 32, TO = 4;

  logic clk = 1'b0, reset_n = 1'b0;
  logic timeout_o, busy_o;
  int   checks = 0, errors = 0;

  obi_rr_arbiter_if #(.OBI_AW(AW), .OBI_DW(DW)) bus ();
  obi_rr_arbiter #(.OBI_AW(AW), .OBI_DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .timeout_o(timeout_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  // Reference model: transaction bookkeeping with plain integers.
  int last, own, pend, waited;
  bit outstanding, timed_out, draining, late;

  logic          e_sreq, e_swe, e_srready, e_tmo, e_busy;
  logic [AW-1:0] e_saddr;
  logic [DW/8-1:0] e_sbe;
  logic [DW-1:0] e_swdata, e_rdata0, e_rdata1;
  logic [1:0]    e_gnt, e_rvalid, e_err;
  int            e_win;

  function automatic void model_reset();
    last = 1; own = 0; pend = -1; waited = 0;
    outstanding = 0; timed_out = 0; draining = 0; late = 0;
  endfunction

  function automatic void set_rsp(int m, logic v, logic er, logic [DW-1:0] d);
    e_rvalid[m] = v; e_err[m] = er;
    if (m == 0) e_rdata0 = d; else e_rdata1 = d;
  endfunction

  function automatic void model_eval();
    logic [1:0] rq, rr;
    rq = {bus.m1_req, bus.m0_req};
    rr = {bus.m1_rready, bus.m0_rready};
    e_sreq = 0; e_swe = 0; e_srready = 0; e_tmo = 0; e_busy = 0;
    e_saddr = '0; e_sbe = '0; e_swdata = '0; e_rdata0 = '0; e_rdata1 = '0;
    e_gnt = '0; e_rvalid = '0; e_err = '0; e_win = 0;
    if (!reset_n) return;
    e_busy = outstanding;
    if (!outstanding) begin
      if (pend >= 0)        e_win = pend;
      else if (rq == 2'b11) e_win = 1 - last;
      else if (rq == 2'b10) e_win = 1;
      else                  e_win = 0;
      e_sreq   = rq[e_win];
      e_swe    = e_win == 1 ? bus.m1_we    : bus.m0_we;
      e_saddr  = e_win == 1 ? bus.m1_addr  : bus.m0_addr;
      e_sbe    = e_win == 1 ? bus.m1_be    : bus.m0_be;
      e_swdata = e_win == 1 ? bus.m1_wdata : bus.m0_wdata;
      e_gnt[e_win] = bus.s_gnt;
    end else if (timed_out) begin
      e_srready = 1;
      set_rsp(own, 1'b1, 1'b1, 32'hDEAD_BEEF);
    end else if (draining) begin
      e_srready = 1;
    end else begin
      e_srready = rr[own];
      set_rsp(own, bus.s_rvalid, bus.s_err, bus.s_rdata);
      e_tmo = (waited == TO - 1) && !bus.s_rvalid;
    end
  endfunction

  function automatic void model_update();
    logic [1:0] rr;
    rr = {bus.m1_rready, bus.m0_rready};
    if (!reset_n) begin model_reset(); return; end
    if (!outstanding) begin
      if (e_sreq && bus.s_gnt) begin
        outstanding = 1; own = e_win; last = e_win; waited = 0; pend = -1; late = 0;
      end else pend = e_sreq ? e_win : -1;
    end else if (timed_out) begin
      if (bus.s_rvalid) late = 1;
      if (rr[own]) begin
        timed_out = 0;
        if (late) outstanding = 0; else draining = 1;
      end
    end else if (draining) begin
      if (bus.s_rvalid) begin draining = 0; outstanding = 0; end
    end else begin
      if (bus.s_rvalid && rr[own]) outstanding = 0;
      else if (e_tmo) begin timed_out = 1; late = 0; end
      if (!bus.s_rvalid && waited < 65535) waited++;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mid-cycle half: compare every output against the model.
  task automatic pre();
    #3;
    model_eval();
    chk("s_side", 64'({bus.s_req, bus.s_we, bus.s_rready, bus.s_be, bus.s_addr}),
                  64'({e_sreq, e_swe, e_srready, e_sbe, e_saddr}));
    chk("s_wdata", 64'(bus.s_wdata), 64'(e_swdata));
    chk("m0_rsp", 64'({bus.m0_gnt, bus.m0_rvalid, bus.m0_err, bus.m0_rdata}),
                  64'({e_gnt[0], e_rvalid[0], e_err[0], e_rdata0}));
    chk("m1_rsp", 64'({bus.m1_gnt, bus.m1_rvalid, bus.m1_err, bus.m1_rdata}),
                  64'({e_gnt[1], e_rvalid[1], e_err[1], e_rdata1}));
    chk("ctl", 64'({timeout_o, busy_o}), 64'({e_tmo, e_busy}));
  endtask

  task automatic post();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    pre(); post();
  endtask

  task automatic drive(input logic r0, r1, g, rv, rr0, rr1);
    bus.m0_req = r0; bus.m1_req = r1; bus.s_gnt = g; bus.s_rvalid = rv;
    bus.m0_rready = rr0; bus.m1_rready = rr1;
  endtask

  task automatic rnd_payload();
    bus.m0_addr = $urandom; bus.m1_addr = $urandom;
    bus.m0_wdata = $urandom; bus.m1_wdata = $urandom;
    bus.m0_we = 1'($urandom_range(0, 1)); bus.m1_we = 1'($urandom_range(0, 1));
    bus.m0_be = 4'($urandom); bus.m1_be = 4'($urandom);
    bus.s_rdata = $urandom; bus.s_err = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [DW-1:0] held;
    model_reset();
    rnd_payload();
    drive(1, 1, 1, 0, 1, 1);
    bus.s_err = 0;
    @(posedge clk); #1;
    // Reset held with both managers requesting: everything quiet.
    pre();
    chk("rst_sreq", 64'(bus.s_req), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    post();
    reset_n = 1'b1;

    // Continuous requests, immediate grants: m0, m1, m0, m1.
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 1, 0, 1, 1);
      pre(); chk("rr_gnt", 64'({bus.m1_gnt, bus.m0_gnt}), 64'((k % 2) ? 2'b10 : 2'b01)); post();
      bus.s_rdata = $urandom;
      drive(1, 1, 1, 1, 1, 1);
      pre();
      chk("rr_own_rdata", 64'((k % 2) ? bus.m1_rdata : bus.m0_rdata), 64'(bus.s_rdata));
      chk("rr_other_rdata", 64'((k % 2) ? bus.m0_rdata : bus.m1_rdata), 64'(0));
      post();
    end

    // m0 alone so that m1 would be preferred next; then a stalled m0 must keep the lock.
    drive(1, 0, 1, 0, 1, 1); tick();
    drive(0, 0, 0, 1, 1, 1); tick();
    for (int c = 1; c <= 4; c++) begin
      drive(1, c >= 2, c == 4, 0, 1, 1);
      pre();
      chk("lock_addr", 64'(bus.s_addr), 64'(bus.m0_addr));
      chk("lock_gnt", 64'({bus.m1_gnt, bus.m0_gnt}), 64'(c == 4 ? 2'b01 : 2'b00));
      post();
    end
    drive(0, 1, 0, 1, 1, 1); tick();
    drive(1, 1, 1, 0, 1, 1);
    pre(); chk("lock_next_m1", 64'({bus.m1_gnt, bus.m0_gnt}), 64'(2'b10)); post();
    drive(0, 0, 0, 1, 1, 1); tick();

    // Timeout: no response, error delivered, late response drained.
    drive(1, 0, 1, 0, 0, 0); tick();
    for (int c = 1; c <= 4; c++) begin
      drive(0, 0, 0, 0, 0, 0);
      pre(); chk("tmo_pulse", 64'(timeout_o), 64'(c == 4)); post();
    end
    pre();
    chk("err_rsp", 64'({bus.m0_rvalid, bus.m0_err, bus.m0_rdata}), 64'({2'b11, 32'hDEAD_BEEF}));
    chk("err_srready", 64'(bus.s_rready), 64'(1));
    post();
    drive(0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick(); tick();
    drive(0, 0, 0, 1, 0, 0);
    pre(); chk("drain_rvalid", 64'({bus.m1_rvalid, bus.m0_rvalid, bus.s_rready}), 64'(3'b001)); post();
    drive(0, 0, 0, 0, 0, 0);
    pre(); chk("drain_done", 64'(busy_o), 64'(0)); post();

    // Back-pressure: response held while rready is low.
    drive(0, 1, 1, 0, 0, 0); tick();
    held = $urandom; bus.s_rdata = held;
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 0, 1, 0, 0);
      pre();
      chk("bp_srready", 64'(bus.s_rready), 64'(0));
      chk("bp_rdata", 64'({bus.m1_rvalid, bus.m1_rdata}), 64'({1'b1, held}));
      post();
    end
    drive(0, 0, 0, 1, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0);
    pre(); chk("bp_done", 64'(busy_o), 64'(0)); post();

    // Response in the same cycle the counter reaches TIMEOUT-1.
    drive(1, 0, 1, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 1, 1); tick(); tick(); tick();
    drive(0, 0, 0, 1, 1, 1);
    pre(); chk("edge_no_tmo", 64'({timeout_o, bus.m0_rvalid}), 64'(2'b01)); post();
    drive(0, 0, 0, 0, 1, 1);
    pre(); chk("edge_done", 64'(busy_o), 64'(0)); post();

    // Late response while the error is still pending: straight back to IDLE.
    drive(1, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick(); tick(); tick(); tick();
    drive(0, 0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick();
    pre(); chk("late_idle", 64'(busy_o), 64'(0)); post();

    // Asynchronous reset in the middle of a response.
    drive(1, 1, 1, 0, 1, 1); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", 64'({bus.s_req, bus.s_rready, bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid,
                         bus.m1_rvalid, bus.m0_err, bus.m1_err, timeout_o, busy_o}), 64'(0));
    @(posedge clk); model_reset(); #1;
    tick();
    reset_n = 1'b1;
    pre(); chk("arst_m0_first", 64'({bus.m1_gnt, bus.m0_gnt}), 64'(2'b01)); post();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rnd_payload();
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
      reset_n = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
